// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall sequencer for the 5-stage 16-bit pipeline.
// Stage enable/flush controls are combinational from state and inputs so they act
// in the same cycle; halted, mem_err and stall_cycles are registered status.
module pipeline_ctrl #(
    parameter int REG_W       = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              load_use;
    logic              mem_stall;
    logic              timeout;
    logic              set_halted;
    logic              set_err;
    logic              count_stall;

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use  = idex_memread && (idex_rd != '0) &&
                       ((id_uses_rs && (id_rs == idex_rd)) || (id_uses_rt && (id_rt == idex_rd)));
    assign mem_stall = mem_req && !mem_ack;
    // wait_cnt is zero on the first stalled cycle, so this fires on the stall after MEM_TIMEOUT waits.
    assign timeout   = mem_stall && (wait_cnt == WAIT_LIMIT);

    // Next state, wait counting and the same-cycle stage controls; reset forces every stage quiet.
    always_comb begin
        next_state    = state;
        wait_cnt_next = '0;
        set_halted    = 1'b0;
        set_err       = 1'b0;
        count_stall   = 1'b0;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        memwb_flush   = 1'b0;

        case (state)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                    count_stall = 1'b1;
                    if (timeout) begin
                        set_err    = 1'b1;
                        set_halted = 1'b1;
                        next_state = HALTED;
                    end else begin
                        wait_cnt_next = wait_cnt + WAIT_W'(1);
                        next_state    = MEM_WAIT;
                    end
                end else begin
                    next_state = RUN;
                    if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_flush  = 1'b1;
                        count_stall = 1'b1;
                    end else if (id_halt) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (mem_stall) begin
                    pc_en         = 1'b0;
                    ifid_en       = 1'b0;
                    idex_en       = 1'b0;
                    exmem_en      = 1'b0;
                    memwb_flush   = 1'b1;
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end else begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
                if (timeout) begin
                    set_err       = 1'b1;
                    set_halted    = 1'b1;
                    wait_cnt_next = '0;
                    next_state    = HALTED;
                end else if (memwb_halt) begin
                    set_halted = 1'b1;
                    next_state = HALTED;
                end
            end
            HALTED: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                idex_flush  = 1'b1;
                memwb_flush = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase

        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            count_stall = 1'b0;
            set_halted  = 1'b0;
            set_err     = 1'b0;
        end
    end

    // State and memory-wait counter; reset returns to RUN from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Status: halted and mem_err stick until reset, stall_cycles saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            halted       <= 1'b0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (set_halted) begin
                halted <= 1'b1;
            end
            if (set_err) begin
                mem_err <= 1'b1;
            end
            if (count_stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl.
// The stimulus process drives inputs just after each rising edge and queues the response
// predicted by a behavioural model; a monitor pops and compares on every falling edge.
module tb_pipeline_ctrl;

    localparam int REG_W       = 3;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;
    localparam int SAT         = (1 << CNT_W) - 1;

    logic             clk          = 1'b0;
    logic             reset        = 1'b1;
    logic [REG_W-1:0] id_rs        = '0;
    logic [REG_W-1:0] id_rt        = '0;
    logic             id_uses_rs   = 1'b0;
    logic             id_uses_rt   = 1'b0;
    logic             id_halt      = 1'b0;
    logic             idex_memread = 1'b0;
    logic [REG_W-1:0] idex_rd      = '0;
    logic             branch_taken = 1'b0;
    logic             mem_req      = 1'b0;
    logic             mem_ack      = 1'b0;
    logic             memwb_halt   = 1'b0;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_flush;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    typedef struct packed {
        logic             reset;
        logic [REG_W-1:0] id_rs;
        logic [REG_W-1:0] id_rt;
        logic             id_uses_rs;
        logic             id_uses_rt;
        logic             id_halt;
        logic             idex_memread;
        logic [REG_W-1:0] idex_rd;
        logic             branch_taken;
        logic             mem_req;
        logic             mem_ack;
        logic             memwb_halt;
    } stim_t;

    typedef struct packed {
        int               cyc;
        logic             pc_en;
        logic             ifid_en;
        logic             ifid_flush;
        logic             idex_en;
        logic             idex_flush;
        logic             exmem_en;
        logic             memwb_flush;
        logic             halted;
        logic             mem_err;
        logic [CNT_W-1:0] stall_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Reference model state, described in pipeline terms rather than controller states.
    bit   m_draining = 1'b0;
    bit   m_halted   = 1'b0;
    bit   m_err      = 1'b0;
    int   m_run      = 0;
    int   m_total    = 0;

    pipeline_ctrl #(
        .REG_W       (REG_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_halt      (id_halt),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .memwb_halt   (memwb_halt),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .memwb_flush  (memwb_flush),
        .halted       (halted),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Predict this cycle's controls and visible status, then advance the model past the edge.
    task automatic modelStep(input stim_t s, output exp_t e);
        bit stall_mem;
        bit hazard;
        e              = '0;
        e.cyc          = cyc_no;
        e.halted       = m_halted;
        e.mem_err      = m_err;
        e.stall_cycles = CNT_W'((m_total > SAT) ? SAT : m_total);
        e.pc_en        = 1'b1;
        e.ifid_en      = 1'b1;
        e.idex_en      = 1'b1;
        e.exmem_en     = 1'b1;
        stall_mem      = s.mem_req && !s.mem_ack;
        hazard         = s.idex_memread && (s.idex_rd != 0) &&
                         ((s.id_uses_rs && (s.id_rs == s.idex_rd)) ||
                          (s.id_uses_rt && (s.id_rt == s.idex_rd)));
        if (s.reset) begin
            e.pc_en       = 1'b0;
            e.ifid_en     = 1'b0;
            e.idex_en     = 1'b0;
            e.exmem_en    = 1'b0;
            e.ifid_flush  = 1'b1;
            e.idex_flush  = 1'b1;
            e.memwb_flush = 1'b1;
            m_draining    = 1'b0;
            m_halted      = 1'b0;
            m_err         = 1'b0;
            m_run         = 0;
            m_total       = 0;
        end else if (m_halted) begin
            e.pc_en       = 1'b0;
            e.ifid_en     = 1'b0;
            e.idex_en     = 1'b0;
            e.exmem_en    = 1'b0;
            e.idex_flush  = 1'b1;
            e.memwb_flush = 1'b1;
        end else if (stall_mem) begin
            e.pc_en       = 1'b0;
            e.ifid_en     = 1'b0;
            e.idex_en     = 1'b0;
            e.exmem_en    = 1'b0;
            e.memwb_flush = 1'b1;
            if (!m_draining) m_total++;
            if (m_run == MEM_TIMEOUT) begin
                m_err    = 1'b1;
                m_halted = 1'b1;
            end else begin
                m_run++;
                if (m_draining && s.memwb_halt) m_halted = 1'b1;
            end
        end else begin
            m_run = 0;
            if (m_draining) begin
                e.pc_en      = 1'b0;
                e.ifid_flush = 1'b1;
                if (s.memwb_halt) m_halted = 1'b1;
            end else if (s.branch_taken) begin
                e.ifid_flush = 1'b1;
                e.idex_flush = 1'b1;
            end else if (hazard) begin
                e.pc_en      = 1'b0;
                e.ifid_en    = 1'b0;
                e.idex_flush = 1'b1;
                m_total++;
            end else if (s.id_halt) begin
                m_draining = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the predicted response.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = s.reset;
        id_rs        = s.id_rs;
        id_rt        = s.id_rt;
        id_uses_rs   = s.id_uses_rs;
        id_uses_rt   = s.id_uses_rt;
        id_halt      = s.id_halt;
        idex_memread = s.idex_memread;
        idex_rd      = s.idex_rd;
        branch_taken = s.branch_taken;
        mem_req      = s.mem_req;
        mem_ack      = s.mem_ack;
        memwb_halt   = s.memwb_halt;
        modelStep(s, e);
        exp_q.push_back(e);
        cyc_no++;
    endtask

    task automatic checkOutput(input string name, input int cyc, input logic [31:0] act,
                               input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("pc_en",        e.cyc, 32'(pc_en),        32'(e.pc_en));
                checkOutput("ifid_en",      e.cyc, 32'(ifid_en),      32'(e.ifid_en));
                checkOutput("ifid_flush",   e.cyc, 32'(ifid_flush),   32'(e.ifid_flush));
                checkOutput("idex_en",      e.cyc, 32'(idex_en),      32'(e.idex_en));
                checkOutput("idex_flush",   e.cyc, 32'(idex_flush),   32'(e.idex_flush));
                checkOutput("exmem_en",     e.cyc, 32'(exmem_en),     32'(e.exmem_en));
                checkOutput("memwb_flush",  e.cyc, 32'(memwb_flush),  32'(e.memwb_flush));
                checkOutput("halted",       e.cyc, 32'(halted),       32'(e.halted));
                checkOutput("mem_err",      e.cyc, 32'(mem_err),      32'(e.mem_err));
                checkOutput("stall_cycles", e.cyc, 32'(stall_cycles), 32'(e.stall_cycles));
            end
        end
    end

    // Directed scenarios first, then weighted random traffic, then the summary.
    initial begin
        stim_t s;
        int    slow_left;
        $display("[TB] pipeline_ctrl bench start");

        s = idle(); s.reset = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idle());

        s = idle(); s.idex_memread = 1'b1; s.idex_rd = 3'd3; s.id_rs = 3'd3; s.id_uses_rs = 1'b1;
        applyStimulus(s);
        applyStimulus(idle());

        s = idle(); s.idex_memread = 1'b1; s.idex_rd = 3'd5; s.id_rt = 3'd5; s.id_uses_rt = 1'b1;
        applyStimulus(s);
        s = idle(); s.idex_memread = 1'b1; s.idex_rd = 3'd6; s.id_rs = 3'd6; s.id_uses_rs = 1'b0;
        applyStimulus(s);

        s = idle(); s.idex_memread = 1'b1; s.idex_rd = 3'd0; s.id_rs = 3'd0; s.id_rt = 3'd0;
        s.id_uses_rs = 1'b1; s.id_uses_rt = 1'b1;
        applyStimulus(s);

        s = idle(); s.mem_req = 1'b1;
        repeat (3) applyStimulus(s);
        s.mem_ack = 1'b1;
        applyStimulus(s);
        applyStimulus(idle());

        s = idle(); s.branch_taken = 1'b1; s.idex_memread = 1'b1; s.idex_rd = 3'd2;
        s.id_rs = 3'd2; s.id_uses_rs = 1'b1; s.id_halt = 1'b1;
        applyStimulus(s);
        applyStimulus(idle());

        s = idle(); s.mem_req = 1'b1;
        applyStimulus(s);
        s.mem_ack = 1'b1; s.id_halt = 1'b1;
        applyStimulus(s);
        applyStimulus(idle());
        s = idle(); s.mem_req = 1'b1;
        repeat (2) applyStimulus(s);
        applyStimulus(idle());
        s = idle(); s.memwb_halt = 1'b1;
        applyStimulus(s);
        repeat (2) applyStimulus(idle());
        s = idle(); s.reset = 1'b1;
        applyStimulus(s);
        applyStimulus(idle());

        s = idle(); s.mem_req = 1'b1;
        repeat (MEM_TIMEOUT + 3) applyStimulus(s);
        repeat (2) applyStimulus(idle());
        s = idle(); s.reset = 1'b1;
        applyStimulus(s);
        repeat (2) applyStimulus(idle());

        s = idle(); s.id_halt = 1'b1;
        applyStimulus(s);
        repeat (3) applyStimulus(idle());
        s = idle(); s.memwb_halt = 1'b1;
        applyStimulus(s);
        repeat (3) applyStimulus(idle());
        s = idle(); s.reset = 1'b1;
        applyStimulus(s);

        slow_left = 0;
        for (int i = 0; i < 3000; i++) begin
            s              = idle();
            s.reset        = ($urandom_range(0, 299) == 0) || (m_halted && ($urandom_range(0, 5) == 0));
            s.id_rs        = REG_W'($urandom_range(0, 3));
            s.id_rt        = REG_W'($urandom_range(0, 3));
            s.id_uses_rs   = 1'($urandom_range(0, 1));
            s.id_uses_rt   = 1'($urandom_range(0, 1));
            s.id_halt      = ($urandom_range(0, 39) == 0);
            s.idex_memread = ($urandom_range(0, 2) == 0);
            s.idex_rd      = REG_W'($urandom_range(0, 3));
            s.branch_taken = ($urandom_range(0, 7) == 0);
            s.memwb_halt   = ($urandom_range(0, 3) == 0);
            if ((slow_left == 0) && ($urandom_range(0, 99) == 0)) begin
                slow_left = int'($urandom_range(MEM_TIMEOUT - 2, MEM_TIMEOUT + 4));
            end
            if (slow_left > 0) begin
                s.mem_req = 1'b1;
                s.mem_ack = 1'b0;
                slow_left--;
            end else begin
                s.mem_req = ($urandom_range(0, 3) == 0);
                s.mem_ack = 1'($urandom_range(0, 1));
            end
            applyStimulus(s);
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", cyc_no, 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
